skinny_inv_sbox8_para1_hs: RTL and testbench
============================================

# skinny_inv_sbox8_para1_hs

First-order masked SKINNY-128 inverse 8-bit S-box for the decryption datapath. It computes S8^-1 on two Boolean shares using eight NOR-based masked gadgets at dependency depth 4. A valid/ready controller captures the shares and the refresh mask, and holds them stable for the full evaluation. It registers the result shares and presents them until the consumer accepts them.

## Interface
- LAT, 8, busy cycles from capture to result register load; must be >= 8, which is 2 register stages per gadget times depth 4.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input shares and mask are valid
- in_ready  output  1  block can accept an input
- si0  input  8  input share 0
- si1  input  8  input share 1
- r  input  16  fresh refresh mask, two bits per gadget
- out_valid  output  1  result shares valid
- out_ready  input  1  consumer accepts the result
- bo0  output  8  output share 0
- bo1  output  8  output share 1

## Operation
- Unmasked function: (bo0^bo1) = S8^-1(si0^si1), where S8 is the SKINNY-128 8-bit S-box.
- Gadget g(x,y,z; r2) has 2-bit shared inputs and two register stages:
  - stage 1: g1 = (~x1&~y1)^r1 and g0 = (x0&y0)^r0.
  - stage 2: t1 = (~x1&y0)^r0^g1^z0 and t0 = (~y1&x0)^r1^g0^z1.
  - Result share pair {t1,t0} equals z ^ NOR(x,y) when unmasked.
- Let o be the captured input, with bit pair k = {si1[k],si0[k]}. Recover input bits b of the forward S-box:
  - layer 1: b2 = g(o3,o1; o0) uses r[1:0]. b3 = g(o7,o6; o4) uses r[3:2]. b7 = g(o2,o7; o1) uses r[5:4]. b5 = g(o6,o5; o7) uses r[7:6].
  - layer 2: b1 = g(o5,b3; o3) uses r[9:8]. b0 = g(b3,b2; o5) uses r[11:10].
  - layer 3: b6 = g(b2,b1; o2) uses r[13:12].
  - layer 4: b4 = g(b7,b6; o6) uses r[15:14].
- Result register bit k holds share pair bk.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture si0, si1 and r into hold registers, clear the counter, go to BUSY.
  - BUSY: in_ready=0. Hold registers are frozen and the counter increments. When the counter reaches LAT-1, load bo0/bo1 from the gadget outputs, go to DONE.
  - DONE: out_valid=1 and bo0/bo1 are frozen. When out_ready=1, go to IDLE.
- Hold registers change only on capture. Gadget registers clock freely. Outputs come only from the result register, never directly from gadget outputs.
- Reset state: IDLE, counter 0, hold registers 0, bo0=bo1=0, out_valid=0, in_ready=1. Gadget registers are not reset.
- Reset mid-operation (BUSY or DONE) abandons the operation. No output is produced for it.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Share independence: the two shares of each gadget combine only through the registered cross terms above. No combinational share recombination exists anywhere in the block.

## Timing
- Capture handshake in cycle 0. out_valid rises LAT cycles after the capture edge; the default is 8.
- In DONE, out_valid&out_ready completes the transfer. in_ready=1 on the next cycle. A new capture is possible in that cycle.
- There is no bypass: throughput is one result per LAT+2 cycles when out_ready is held at 1.
- bo0/bo1 and out_valid are stable while out_valid=1 and out_ready=0, for any stall length.
- in_ready depends only on state. There is no combinational path from out_ready to in_ready.

## Test plan
- After reset, with si0=0x65, si1=0x00, r=0 and in_valid pulsed: out_valid rises 8 cycles after capture, and bo0^bo1=0x00.
- si0=0x4c^M and si1=M for random M, with random r: bo0^bo1=0x01. Repeat with input 0xff: result 0xff.
- Exhaustive sweep of all 256 unmasked inputs with random shares and random r: bo0^bo1 = S8^-1(x) for every x. S8(S8^-1(x))=x is cross-checked against the forward S-box model.
- Hold out_ready=0 for 20 cycles in DONE: outputs are unchanged, in_ready=0, and a new in_valid pulse is ignored. On release, exactly one transfer occurs.
- Change si0/si1/r every cycle during BUSY: the result reflects the captured values only.
- Assert rst_n low in BUSY cycle 3: out_valid=0, bo0=bo1=0 and in_ready=1 immediately. The next operation is correct.

Source files
------------

// File: rtl/skinny_inv_sbox8_para1_hs.sv
// Two-share SKINNY-128 inverse 8-bit S-box built from eight NOR gadgets at depth 4.
// A valid/ready wrapper freezes the captured shares while the gadget pipeline settles.

module skinny_nor_gadget #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic [1:0] z,
  input  logic [1:0] m,
  output logic [1:0] t
);
  logic [1:0] g;
  logic [1:0] t_c;

  // Only same-index share products are formed before the first register.
  always_ff @(posedge clk) begin
    g[1] <= (~x[1] & ~y[1]) ^ m[1];
    g[0] <= (x[0] & y[0]) ^ m[0];
  end

  assign t_c[1] = (~x[1] & y[0]) ^ m[0] ^ g[1] ^ z[0];
  assign t_c[0] = (~y[1] & x[0]) ^ m[1] ^ g[0] ^ z[1];

  // The last layer leaves its second stage to the result register downstream.
  if (OUT_REG) begin : g_oreg
    always_ff @(posedge clk) t <= t_c;
  end else begin : g_ocomb
    assign t = t_c;
  end
endmodule

module skinny_inv_sbox8_para1_hs #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  si0,
  input  logic [7:0]  si1,
  input  logic [15:0] r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  bo0,
  output logic [7:0]  bo1
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    h0, h1;
  logic [15:0]   hr;
  logic          cap, load_res;
  logic [1:0]    o [8];
  logic [1:0]    b [8];
  logic [7:0]    res0, res1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cap       = 1'b0;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap       = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (cnt == CW'(LAT - 1)) begin
        load_res  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      h0  <= '0;
      h1  <= '0;
      hr  <= '0;
    end else if (cap) begin
      cnt <= '0;
      h0  <= si0;
      h1  <= si1;
      hr  <= r;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end

  for (genvar k = 0; k < 8; k++) begin : g_pair
    assign o[k]    = {h1[k], h0[k]};
    assign res1[k] = b[k][1];
    assign res0[k] = b[k][0];
  end

  // Layer 1 reads only the held shares; each later layer waits two stages on its predecessor.
  skinny_nor_gadget u_b2 (.clk(clk), .x(o[3]), .y(o[1]), .z(o[0]), .m(hr[1:0]),   .t(b[2]));
  skinny_nor_gadget u_b3 (.clk(clk), .x(o[7]), .y(o[6]), .z(o[4]), .m(hr[3:2]),   .t(b[3]));
  skinny_nor_gadget u_b7 (.clk(clk), .x(o[2]), .y(o[7]), .z(o[1]), .m(hr[5:4]),   .t(b[7]));
  skinny_nor_gadget u_b5 (.clk(clk), .x(o[6]), .y(o[5]), .z(o[7]), .m(hr[7:6]),   .t(b[5]));
  skinny_nor_gadget u_b1 (.clk(clk), .x(o[5]), .y(b[3]), .z(o[3]), .m(hr[9:8]),   .t(b[1]));
  skinny_nor_gadget u_b0 (.clk(clk), .x(b[3]), .y(b[2]), .z(o[5]), .m(hr[11:10]), .t(b[0]));
  skinny_nor_gadget u_b6 (.clk(clk), .x(b[2]), .y(b[1]), .z(o[2]), .m(hr[13:12]), .t(b[6]));
  skinny_nor_gadget #(.OUT_REG(1'b0)) u_b4
                         (.clk(clk), .x(b[7]), .y(b[6]), .z(o[6]), .m(hr[15:14]), .t(b[4]));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bo0 <= '0;
      bo1 <= '0;
    end else if (load_res) begin
      bo0 <= res0;
      bo1 <= res1;
    end
endmodule

// File: tb/tb_skinny_inv_sbox8_para1_hs.sv
// Directed bench for the masked inverse S-box: transaction model plus per-cycle compare.
module tb_skinny_inv_sbox8_para1_hs;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  si0 = '0, si1 = '0;
  logic [15:0] r = '0;
  logic        in_ready, out_valid;
  logic [7:0]  bo0, bo1;

  int n_vec = 0, n_err = 0, ops = 0, dut_xfers = 0;
  logic [7:0] inv_tab [256];

  skinny_inv_sbox8_para1_hs #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .si0(si0), .si1(si1), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .bo0(bo0), .bo1(bo1)
  );

  always #5 clk = ~clk;

  // Forward S8 in NOR form: the decryption relations solved for the ciphertext bits.
  function automatic logic [7:0] fwd(input logic [7:0] b);
    logic [7:0] o;
    o[5] = b[0] ^ ~(b[3] | b[2]);
    o[3] = b[1] ^ ~(o[5] | b[3]);
    o[2] = b[6] ^ ~(b[2] | b[1]);
    o[6] = b[4] ^ ~(b[7] | b[6]);
    o[7] = b[5] ^ ~(o[6] | o[5]);
    o[1] = b[7] ^ ~(o[2] | o[7]);
    o[4] = b[3] ^ ~(o[7] | o[6]);
    o[0] = b[2] ^ ~(o[3] | o[1]);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  // Transaction-level model: idle -> LAT cycles busy -> done until accepted.
  logic       m_idle = 1'b1, m_done = 1'b0;
  int         m_left = 0;
  logic [7:0] m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_exp  <= inv_tab[si0 ^ si1];
        m_left <= LAT;
        m_idle <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) dut_xfers <= dut_xfers + 1;

  logic       prev_stall = 1'b0;
  logic [7:0] prev0 = '0, prev1 = '0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_idle));
    chk("out_valid", 32'(out_valid), 32'(m_done));
    if (m_done) begin
      chk("result", 32'(bo0 ^ bo1), 32'(m_exp));
      if (prev_stall) begin
        chk("hold_bo0", 32'(bo0), 32'(prev0));
        chk("hold_bo1", 32'(bo1), 32'(prev1));
      end
    end
    prev_stall <= rst_n && m_done && !out_ready;
    prev0      <= bo0;
    prev1      <= bo1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [7:0] a0, input logic [7:0] a1, input logic [15:0] rr,
                       input int stall, input bit scramble,
                       output logic [7:0] res, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin step(); k++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    si0 = a0; si1 = a1; r = rr; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      if (scramble) begin
        si0 = 8'($urandom); si1 = 8'($urandom); r = 16'($urandom);
      end
      step();
      k++;
    end
    if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
    lat = k;
    res = bo0 ^ bo1;
    for (int i = 0; i < stall; i++) begin
      if (i == 5) begin
        in_valid = 1'b1; si0 = 8'($urandom); si1 = 8'($urandom);
      end
      if (i == 6) in_valid = 1'b0;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ops++;
  endtask

  initial begin
    logic [7:0] res, m;
    int lat, bad;
    for (int x = 0; x < 256; x++) inv_tab[fwd(8'(x))] = 8'(x);

    bad = 0;
    for (int x = 0; x < 256; x++) if (fwd(inv_tab[x]) != 8'(x)) bad++;
    chk("sbox_roundtrip", 32'(bad), 32'd0);
    chk("fwd_00", 32'(fwd(8'h00)), 32'h65);
    chk("fwd_01", 32'(fwd(8'h01)), 32'h4c);
    chk("fwd_02", 32'(fwd(8'h02)), 32'h6a);
    chk("fwd_03", 32'(fwd(8'h03)), 32'h42);
    chk("fwd_ff", 32'(fwd(8'hff)), 32'hff);

    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bo0", 32'(bo0), 32'd0);
    chk("rst_bo1", 32'(bo1), 32'd0);
    rst_n = 1'b1;
    step();

    do_op(8'h65, 8'h00, 16'h0000, 0, 1'b0, res, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_result", 32'(res), 32'h00);

    for (int i = 0; i < 3; i++) begin
      m = 8'($urandom);
      do_op(8'h4c ^ m, m, 16'($urandom), 0, 1'b0, res, lat);
      chk("t2_result_01", 32'(res), 32'h01);
    end
    m = 8'($urandom);
    do_op(8'hff ^ m, m, 16'($urandom), 0, 1'b0, res, lat);
    chk("t2_result_ff", 32'(res), 32'hff);

    m = 8'($urandom);
    do_op(8'h42 ^ m, m, 16'($urandom), 20, 1'b0, res, lat);
    chk("stall_result", 32'(res), 32'h03);
    step();
    chk("stall_xfers", 32'(dut_xfers), 32'(ops));

    m = 8'($urandom);
    do_op(8'h6a ^ m, m, 16'($urandom), 0, 1'b1, res, lat);
    chk("scramble_result", 32'(res), 32'h02);

    for (int x = 0; x < 256; x++) begin
      m = 8'($urandom);
      do_op(8'(x) ^ m, m, 16'($urandom), 0, 1'b0, res, lat);
      chk("sweep", 32'(res), 32'(inv_tab[x]));
      if (lat != LAT) chk("sweep_latency", 32'(lat), 32'(LAT));
    end

    // Abandon an operation in its third busy cycle.
    m = 8'($urandom);
    si0 = 8'h11 ^ m; si1 = m; r = 16'($urandom); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bo0", 32'(bo0), 32'd0);
    chk("midrst_bo1", 32'(bo1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    m = 8'($urandom);
    do_op(8'h65 ^ m, m, 16'($urandom), 0, 1'b0, res, lat);
    chk("post_rst_result", 32'(res), 32'h00);
    chk("post_rst_latency", 32'(lat), 32'd8);

    step();
    chk("total_xfers", 32'(dut_xfers), 32'(ops));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
